// File: rtl/truth_table_sweeper.sv
// Self-sequencing truth-table evaluator: latches a table on start and walks every input combination.
// Optional minterm counter is compiled in when TRUTH_TABLE_SWEEPER_COUNT_EN is defined.
module truth_table_sweeper #(
    parameter int N_IN = 3,
    parameter int HOLD = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [2**N_IN-1:0]   table_in,
    output logic                 busy,
    output logic                 valid,
    output logic [N_IN-1:0]      in_vec,
    output logic                 f,
    output logic                 done,
    output logic [N_IN:0]        ones_count
);

    localparam int NCOMB = 2**N_IN;
    localparam int HW    = 8;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t            state_reg;
    state_t            state_next;
    logic [NCOMB-1:0]  table_reg;
    logic [N_IN-1:0]   in_vec_reg;
    logic [HW-1:0]     hold_reg;
    logic              last_hold;
    logic              last_vec;
    logic              accept;

    assign last_hold = (hold_reg == HW'(HOLD - 1));
    assign last_vec  = (in_vec_reg == {N_IN{1'b1}});
    assign accept    = (state_reg == IDLE) && start;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (start) state_next = RUN;
            RUN: begin
                // abort takes priority over finishing on the last hold cycle
                if (abort)
                    state_next = IDLE;
                else if (last_hold && last_vec)
                    state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            table_reg  <= '0;
            in_vec_reg <= '0;
            hold_reg   <= '0;
        end else if (accept) begin
            table_reg  <= table_in;
            in_vec_reg <= '0;
            hold_reg   <= '0;
        end else if (state_reg == RUN && !abort) begin
            if (last_hold) begin
                hold_reg <= '0;
                if (!last_vec)
                    in_vec_reg <= in_vec_reg + N_IN'(1);
            end else begin
                hold_reg <= hold_reg + HW'(1);
            end
        end
    end

    assign busy   = (state_reg == RUN);
    assign valid  = busy && (hold_reg == '0);
    assign done   = (state_reg == DONE);
    assign in_vec = in_vec_reg;
    // f comes only from the latched copy, never from table_in
    assign f      = table_reg[in_vec_reg];

`ifdef TRUTH_TABLE_SWEEPER_COUNT_EN
    logic [N_IN:0] ones_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ones_reg <= '0;
        else if (accept)
            ones_reg <= '0;
        else if (valid)
            ones_reg <= ones_reg + (N_IN+1)'(f);
    end

    assign ones_count = ones_reg;
`else
    assign ones_count = '0;
`endif

endmodule
